// File: rtl/axi_ram_ext.sv
// AXI4 slave memory model with address-window decode, WRAP bursts, SLVERR/DECERR
// reporting and programmable read latency. Read and write paths are independent.
module axi_ram_ext #(
    parameter int                    DATA_WIDTH     = 64,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    STRB_WIDTH     = DATA_WIDTH/8,
    parameter int                    ID_WIDTH       = 4,
    parameter int                    MEM_ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    READ_LATENCY   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int         STRB_LOG  = $clog2(STRB_WIDTH);
    localparam int         IDX_WIDTH = MEM_ADDR_WIDTH - STRB_LOG;
    localparam logic [2:0] MAX_SIZE  = 3'(STRB_LOG);
    localparam logic [3:0] LATENCY   = 4'(READ_LATENCY);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;

    logic [DATA_WIDTH-1:0] mem [2**IDX_WIDTH];

    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (off >> MEM_ADDR_WIDTH) == '0;
    endfunction

    function automatic logic [IDX_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return off[STRB_LOG +: IDX_WIDTH];
    endfunction

    function automatic logic [1:0] burst_status(input logic [ADDR_WIDTH-1:0] addr,
                                                input logic [7:0] len, input logic [2:0] size,
                                                input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] mask;
        logic                  bad_len;
        mask    = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
        bad_len = len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15;
        if (!in_window(addr))
            return RESP_DECERR;
        if (size > MAX_SIZE || burst == BURST_RSVD)
            return RESP_SLVERR;
        if (burst == BURST_WRAP && (bad_len || (addr & mask) != '0))
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    // Reserved burst types only ever appear on error bursts, so they advance like INCR.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len, input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] bytes, container, lower, nxt;
        bytes     = ADDR_WIDTH'(1) << size;
        container = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * bytes;
        lower     = addr & ~(container - ADDR_WIDTH'(1));
        nxt       = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
        if (burst == BURST_FIXED)
            nxt = addr;
        else if (burst == BURST_WRAP) begin
            nxt = addr + bytes;
            if (nxt == lower + container)
                nxt = lower;
        end
        return nxt;
    endfunction

    w_state_t              w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst, w_status, w_final_resp;
    logic                  w_dec, w_last_err, w_fire, w_beat_dec, w_last_bad, mem_we;

    assign w_fire     = w_state == W_DATA && s_axi_wvalid && s_axi_wready;
    assign w_beat_dec = w_status == RESP_OKAY && !in_window(w_addr);
    assign w_last_bad = s_axi_wlast != (w_cnt == 8'd0);
    assign mem_we     = w_fire && w_status == RESP_OKAY && !w_beat_dec;

    always_comb begin
        w_final_resp = RESP_OKAY;
        if (w_status != RESP_OKAY)
            w_final_resp = w_status;
        else if (w_dec || w_beat_dec)
            w_final_resp = RESP_DECERR;
        else if (w_last_err || w_last_bad)
            w_final_resp = RESP_SLVERR;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            for (int i = 0; i < STRB_WIDTH; i++)
                if (s_axi_wstrb[i])
                    mem[word_index(w_addr)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
    end

    // Write FSM: errors seen during the burst accumulate into the single B response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_bid     <= '0;
            w_id          <= '0;
            w_addr        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_status      <= RESP_OKAY;
            w_dec         <= 1'b0;
            w_last_err    <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awvalid && s_axi_awready) begin
                        w_id          <= s_axi_awid;
                        w_addr        <= s_axi_awaddr;
                        w_len         <= s_axi_awlen;
                        w_cnt         <= s_axi_awlen;
                        w_size        <= s_axi_awsize;
                        w_burst       <= s_axi_awburst;
                        w_status      <= burst_status(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
                        w_dec         <= 1'b0;
                        w_last_err    <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_dec      <= w_dec || w_beat_dec;
                        w_last_err <= w_last_err || w_last_bad;
                        if (w_cnt == 8'd0) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= w_id;
                            s_axi_bresp  <= w_final_resp;
                            w_state      <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt - 8'd1;
                            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                        end
                    end
                end
                default: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
            endcase
        end
    end

    r_state_t              r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst, r_status, r_beat_resp;
    logic [3:0]            r_wait;
    logic                  r_load, r_done;

    assign r_beat_resp = (r_status != RESP_OKAY) ? r_status :
                         in_window(r_addr)       ? RESP_OKAY : RESP_DECERR;
    assign r_done      = r_state == R_BURST && s_axi_rvalid && s_axi_rready && s_axi_rlast;
    assign r_load      = (r_state == R_WAIT && r_wait == 4'd0) ||
                         (r_state == R_BURST && s_axi_rvalid && s_axi_rready && !s_axi_rlast);

    // Read FSM: a new beat is loaded when the wait expires or the previous beat is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            r_id          <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_status      <= RESP_OKAY;
            r_wait        <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_id          <= s_axi_arid;
                        r_addr        <= s_axi_araddr;
                        r_len         <= s_axi_arlen;
                        r_cnt         <= s_axi_arlen;
                        r_size        <= s_axi_arsize;
                        r_burst       <= s_axi_arburst;
                        r_status      <= burst_status(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
                        r_wait        <= LATENCY;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_wait != 4'd0)
                        r_wait <= r_wait - 4'd1;
                end
                default: begin
                    if (r_done) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_rlast   <= 1'b0;
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
            endcase
            if (r_load) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rid    <= r_id;
                s_axi_rresp  <= r_beat_resp;
                s_axi_rdata  <= (r_beat_resp == RESP_OKAY) ? mem[word_index(r_addr)] : '0;
                s_axi_rlast  <= r_cnt == 8'd0;
                r_cnt        <= r_cnt - 8'd1;
                r_addr       <= next_addr(r_addr, r_len, r_size, r_burst);
                r_state      <= R_BURST;
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_ext.sv
// Directed self-checking bench for axi_ram_ext (READ_LATENCY=4, 64-bit data, 64 KiB window at 0).
module tb_axi_ram_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    int checks = 0;
    int errors = 0;

    logic [63:0] w_beats [16];
    logic [63:0] r_data  [16];
    logic [1:0]  r_resp  [16];
    logic        r_last  [16];
    logic [3:0]  r_id0;
    logic [1:0]  got_bresp;
    logic [3:0]  got_bid;

    axi_ram_ext #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .ID_WIDTH(4),
        .MEM_ADDR_WIDTH(16), .BASE_ADDR(32'h0), .READ_LATENCY(4)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        assert (actual === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, actual, expected);
        end
    endtask

    // Full write burst; last_mode 1 raises wlast on beat 0, 2 drops it on the final beat.
    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst, input logic [7:0] strb, input logic [3:0] id,
                                 input int last_mode);
        int n;
        s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
        s_axi_awburst = burst; s_axi_awid = id; s_axi_awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_awready && n < 100) begin @(negedge clk); n++; end
        checkOutput("aw_ready_seen", 64'(s_axi_awready), 64'd1);
        @(posedge clk); #1 s_axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wdata  = w_beats[i];
            s_axi_wstrb  = strb;
            s_axi_wlast  = (i == int'(len));
            if (last_mode == 1 && i == 0) s_axi_wlast = 1'b1;
            if (last_mode == 2 && i == int'(len)) s_axi_wlast = 1'b0;
            s_axi_wvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!s_axi_wready && n < 100) begin @(negedge clk); n++; end
            checkOutput("w_ready_seen", 64'(s_axi_wready), 64'd1);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_bvalid && n < 100) begin @(negedge clk); n++; end
        checkOutput("b_valid_seen", 64'(s_axi_bvalid), 64'd1);
        got_bresp = s_axi_bresp; got_bid = s_axi_bid;
        @(posedge clk); #1 s_axi_bready = 1'b0;
    endtask

    task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id);
        int n;
        s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size;
        s_axi_arburst = burst; s_axi_arid = id; s_axi_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_arready && n < 100) begin @(negedge clk); n++; end
        checkOutput("ar_ready_seen", 64'(s_axi_arready), 64'd1);
        @(posedge clk); #1 s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            @(negedge clk);
            while (!s_axi_rvalid && n < 100) begin @(negedge clk); n++; end
            checkOutput("r_valid_seen", 64'(s_axi_rvalid), 64'd1);
            r_data[i] = s_axi_rdata; r_resp[i] = s_axi_rresp; r_last[i] = s_axi_rlast;
            if (i == 0) r_id0 = s_axi_rid;
            @(posedge clk); #1;
        end
        s_axi_rready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [63:0] held;
        rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

        #23;
        checkOutput("rst_awready", 64'(s_axi_awready), 64'd0);
        checkOutput("rst_arready", 64'(s_axi_arready), 64'd0);
        checkOutput("rst_wready",  64'(s_axi_wready),  64'd0);
        checkOutput("rst_bvalid",  64'(s_axi_bvalid),  64'd0);
        checkOutput("rst_rvalid",  64'(s_axi_rvalid),  64'd0);
        checkOutput("rst_rdata",   s_axi_rdata,        64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_awready", 64'(s_axi_awready), 64'd1);
        checkOutput("post_rst_arready", 64'(s_axi_arready), 64'd1);

        $display("[TB] INCR write/read at 0x100");
        w_beats[0] = 64'hDEADBEEF_CAFEF00D;
        applyStimulus(32'h0, 8'd0, 3'd3, 2'b01, 8'hFF, 4'h1, 0);
        checkOutput("w0_bresp", 64'(got_bresp), 64'd0);
        w_beats[0] = 64'h11; w_beats[1] = 64'h22; w_beats[2] = 64'h33; w_beats[3] = 64'h44;
        applyStimulus(32'h100, 8'd3, 3'd3, 2'b01, 8'hFF, 4'h5, 0);
        checkOutput("incr_bresp", 64'(got_bresp), 64'd0);
        checkOutput("incr_bid",   64'(got_bid),   64'd5);
        readBurst(32'h100, 8'd3, 3'd3, 2'b01, 4'h3);
        checkOutput("incr_rid", 64'(r_id0), 64'd3);
        for (int i = 0; i < 4; i++) begin
            checkOutput("incr_rdata", r_data[i], 64'(32'h11 * (i + 1)));
            checkOutput("incr_rresp", 64'(r_resp[i]), 64'd0);
            checkOutput("incr_rlast", 64'(r_last[i]), 64'(i == 3));
        end

        $display("[TB] read latency and rready backpressure");
        s_axi_araddr = 32'h0; s_axi_arlen = 8'd0; s_axi_arsize = 3'd3;
        s_axi_arburst = 2'b01; s_axi_arid = 4'h2; s_axi_arvalid = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!s_axi_arready && lat < 100) begin @(negedge clk); lat++; end
        @(posedge clk); #1 s_axi_arvalid = 1'b0;
        checkOutput("lat_arready_low", 64'(s_axi_arready), 64'd0);
        lat = 0;
        @(negedge clk);
        while (!s_axi_rvalid && lat < 50) begin lat++; @(negedge clk); end
        checkOutput("lat_negedges_before_rvalid", 64'(lat), 64'd5);
        held = s_axi_rdata;
        checkOutput("lat_rdata", held, 64'hDEADBEEF_CAFEF00D);
        repeat (3) begin
            @(negedge clk);
            checkOutput("hold_rvalid", 64'(s_axi_rvalid), 64'd1);
            checkOutput("hold_rdata",  s_axi_rdata, 64'hDEADBEEF_CAFEF00D);
            checkOutput("hold_rlast",  64'(s_axi_rlast), 64'd1);
        end
        s_axi_rready = 1'b1;
        @(posedge clk); #1 s_axi_rready = 1'b0;
        checkOutput("lat_rvalid_drop", 64'(s_axi_rvalid), 64'd0);
        checkOutput("lat_arready_back", 64'(s_axi_arready), 64'd1);

        $display("[TB] WRAP bursts");
        readBurst(32'h118, 8'd3, 3'd3, 2'b10, 4'h4);
        checkOutput("wrap_b0", r_data[0], 64'h44);
        checkOutput("wrap_b1", r_data[1], 64'h11);
        checkOutput("wrap_b2", r_data[2], 64'h22);
        checkOutput("wrap_b3", r_data[3], 64'h33);
        checkOutput("wrap_rresp", 64'(r_resp[0]), 64'd0);
        checkOutput("wrap_rlast2", 64'(r_last[2]), 64'd0);
        checkOutput("wrap_rlast3", 64'(r_last[3]), 64'd1);
        readBurst(32'h100, 8'd2, 3'd3, 2'b10, 4'h4);
        for (int i = 0; i < 3; i++) begin
            checkOutput("wrap_len2_rresp", 64'(r_resp[i]), 64'd2);
            checkOutput("wrap_len2_rdata", r_data[i], 64'd0);
        end
        checkOutput("wrap_len2_rlast", 64'(r_last[2]), 64'd1);

        $display("[TB] out-of-window write");
        w_beats[0] = 64'hBAD0BAD0_BAD0BAD0; w_beats[1] = 64'hBAD1BAD1_BAD1BAD1;
        applyStimulus(32'h10000, 8'd1, 3'd3, 2'b01, 8'hFF, 4'h6, 0);
        checkOutput("oow_bresp", 64'(got_bresp), 64'd3);
        readBurst(32'h0, 8'd0, 3'd3, 2'b01, 4'h0);
        checkOutput("oow_word0", r_data[0], 64'hDEADBEEF_CAFEF00D);
        readBurst(32'h100, 8'd1, 3'd3, 2'b01, 4'h0);
        checkOutput("oow_w100", r_data[0], 64'h11);
        checkOutput("oow_w108", r_data[1], 64'h22);

        $display("[TB] wlast protocol errors");
        w_beats[0] = 64'h55; w_beats[1] = 64'h66;
        applyStimulus(32'h180, 8'd1, 3'd3, 2'b01, 8'hFF, 4'h7, 1);
        checkOutput("early_wlast_bresp", 64'(got_bresp), 64'd2);
        applyStimulus(32'h180, 8'd1, 3'd3, 2'b01, 8'hFF, 4'h7, 2);
        checkOutput("missing_wlast_bresp", 64'(got_bresp), 64'd2);

        $display("[TB] narrow write");
        w_beats[0] = 64'h01020304_05060708;
        applyStimulus(32'h200, 8'd0, 3'd3, 2'b01, 8'hFF, 4'h8, 0);
        w_beats[0] = 64'h00000000_AA000000;
        applyStimulus(32'h203, 8'd0, 3'd0, 2'b01, 8'h08, 4'h8, 0);
        checkOutput("narrow_bresp", 64'(got_bresp), 64'd0);
        readBurst(32'h200, 8'd0, 3'd3, 2'b01, 4'h0);
        checkOutput("narrow_word", r_data[0], 64'h01020304_AA060708);

        $display("[TB] window edge and oversize reads");
        readBurst(32'hFFF8, 8'd1, 3'd3, 2'b01, 4'h9);
        checkOutput("edge_b0_rresp", 64'(r_resp[0]), 64'd0);
        checkOutput("edge_b1_rresp", 64'(r_resp[1]), 64'd3);
        checkOutput("edge_b1_rdata", r_data[1], 64'd0);
        readBurst(32'h0, 8'd0, 3'd4, 2'b01, 4'h9);
        checkOutput("oversize_rresp", 64'(r_resp[0]), 64'd2);
        checkOutput("oversize_rdata", r_data[0], 64'd0);

        $display("[TB] reset during read burst");
        s_axi_araddr = 32'h100; s_axi_arlen = 8'd7; s_axi_arsize = 3'd3;
        s_axi_arburst = 2'b01; s_axi_arid = 4'hA; s_axi_arvalid = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!s_axi_arready && lat < 100) begin @(negedge clk); lat++; end
        @(posedge clk); #1 s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!s_axi_rvalid && lat < 100) begin @(negedge clk); lat++; end
        checkOutput("rst_burst_beat1", s_axi_rdata, 64'h11);
        @(posedge clk); #1;
        checkOutput("rst_burst_beat2_valid", 64'(s_axi_rvalid), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_rvalid",  64'(s_axi_rvalid),  64'd0);
        checkOutput("midrst_arready", 64'(s_axi_arready), 64'd0);
        checkOutput("midrst_rdata",   s_axi_rdata,        64'd0);
        s_axi_rready = 1'b0;
        @(negedge clk) rst = 1'b0;
        #1 checkOutput("release_arready_low", 64'(s_axi_arready), 64'd0);
        @(posedge clk); #1;
        checkOutput("release_arready_high", 64'(s_axi_arready), 64'd1);
        checkOutput("release_awready_high", 64'(s_axi_awready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
